// File: rtl/md_issue_ctrl.sv
// Initiator side of the HI/LO multiply-divide unit interface: request decode, shadow busy timer,
// D-stage stall, protocol-mismatch flag and performance counters.
module md_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_md_type,
    input  logic [3:0]  e_md_type,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    output logic [1:0]  md_we,
    output logic [31:0] md_wd,
    output logic [31:0] mf_data,
    output logic        stall_d,
    output logic        proto_err,
    output logic [31:0] issue_cnt,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MULT_OP  = 4'd1;
    localparam logic [3:0] MULTU_OP = 4'd2;
    localparam logic [3:0] DIV_OP   = 4'd3;
    localparam logic [3:0] DIVU_OP  = 4'd4;

    typedef enum logic [1:0] {StIdle, StBusyMul, StBusyDiv} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy;
    logic       armed_q;
    logic       d_is_md;

    always_comb begin
        md_start = 1'b0;
        md_op    = 4'd0;
        md_we    = 2'b00;
        mf_data  = 32'd0;
        case (e_md_type)
            4'd1: begin md_start = 1'b1; md_op = MULT_OP;  end
            4'd2: begin md_start = 1'b1; md_op = MULTU_OP; end
            4'd3: begin md_start = 1'b1; md_op = DIV_OP;   end
            4'd4: begin md_start = 1'b1; md_op = DIVU_OP;  end
            4'd5: mf_data = md_hi;
            4'd6: mf_data = md_lo;
            4'd7: md_we = 2'b01;
            4'd8: md_we = 2'b11;
            default: ;
        endcase
    end

    assign md_d1 = e_rs;
    assign md_d2 = e_rt;
    assign md_wd = e_rs;

    assign busy    = (state_q != StIdle);
    assign d_is_md = (d_md_type >= 4'd1) && (d_md_type <= 4'd8);
    // md_start covers the issue cycle, before the MDU has raised busy.
    assign stall_d = d_is_md && (busy || md_start);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (md_start) begin
                    if (md_op == MULT_OP || md_op == MULTU_OP) begin
                        state_d = StBusyMul;
                        cnt_d   = 8'(MUL_LAT);
                    end else begin
                        state_d = StBusyDiv;
                        cnt_d   = 8'(DIV_LAT);
                    end
                end
            end
            StBusyMul, StBusyDiv: begin
                if (cnt_q == 8'd1) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            armed_q   <= 1'b0;
            proto_err <= 1'b0;
            issue_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
            // The first cycle out of reset is exempt while the MDU settles.
            if ((armed_q && (md_busy != busy)) || (busy && md_start)) begin
                proto_err <= 1'b1;
            end
            if (md_start || md_we[0]) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (stall_d) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule
